// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder CPU memory model.
package mem_responder_pkg;

   localparam int unsigned WORD_SIZE_DFLT = 16;
   localparam int unsigned MEM_DEPTH_DFLT = 256;
   localparam int unsigned LATENCY_DFLT   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESP    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage with one synchronous write port and one registered read port.
module mem_responder_mem_array #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Latency-configurable memory responder for a CPU with readM/writeM handshakes
// and a shared bidirectional data bus.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WORD_SIZE_DFLT,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DFLT,
   parameter int unsigned LATENCY   = LATENCY_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 readM,
   input  logic                 writeM,
   input  logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   output logic                 inputReady,
   output logic                 ackOutput
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t               state, state_n;
   op_t                  op, op_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [AW-1:0]        addr_q, addr_n;
   logic [WORD_SIZE-1:0] wdata_q, wdata_n;
   logic [WORD_SIZE-1:0] rd_word;
   logic                 drive;
   logic                 req_active;
   logic                 mem_we, mem_re;
   logic                 unused_addr_hi;

   // Upper address bits are ignored so the array wraps around.
   assign unused_addr_hi = ^address[WORD_SIZE-1:AW];

   assign req_active = (op == OP_WRITE) ? writeM : readM;

   // Next-state, request capture and memory strobes.
   always_comb begin
      state_n = state;
      op_n    = op;
      cnt_n   = cnt;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (readM ^ writeM) begin
               op_n    = writeM ? OP_WRITE : OP_READ;
               addr_n  = address[AW-1:0];
               wdata_n = data;
               cnt_n   = CW'(LATENCY - 1);
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req_active) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else if (cnt == '0) begin
               // Reset on this edge must suppress the commit.
               mem_we  = (op == OP_WRITE) && !reset;
               mem_re  = (op == OP_READ) && !reset;
               state_n = ST_RESP;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         ST_RESP: state_n = ST_RELEASE;
         ST_RELEASE: begin
            if (!readM && !writeM) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         op         <= OP_READ;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         inputReady <= 1'b0;
         ackOutput  <= 1'b0;
         drive      <= 1'b0;
      end else begin
         state      <= state_n;
         op         <= op_n;
         cnt        <= cnt_n;
         addr_q     <= addr_n;
         wdata_q    <= wdata_n;
         inputReady <= mem_re;
         ackOutput  <= mem_we;
         drive      <= mem_re;
      end
   end

   // The bus is only ours for the single response cycle of a read.
   assign data = drive ? rd_word : {WORD_SIZE{1'bz}};

   mem_responder_mem_array #(
      .WIDTH (WORD_SIZE),
      .DEPTH (MEM_DEPTH),
      .ADDR_W(AW)
   ) mem_array (
      .clk  (clk),
      .we   (mem_we),
      .waddr(addr_q),
      .wdata(wdata_q),
      .re   (mem_re),
      .raddr(addr_q),
      .rdata(rd_word)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// reset-in-WAIT sequence, and random transactions against a transaction-level model.
module tb_mem_responder;

   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 256;
   localparam int          LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        readM;
   logic        writeM;
   logic [15:0] address;
   logic [15:0] cpu_wdata;
   logic        cpu_oe;
   wire  [15:0] data;
   logic        inputReady;
   logic        ackOutput;

   assign data = cpu_oe ? cpu_wdata : 16'hzzzz;

   always #5 clk = ~clk;

   mem_responder #(
      .WORD_SIZE(W),
      .MEM_DEPTH(DEPTH),
      .LATENCY  (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .readM     (readM),
      .writeM    (writeM),
      .address   (address),
      .data      (data),
      .inputReady(inputReady),
      .ackOutput (ackOutput)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] ref_mem [DEPTH];
   bit          ref_valid [DEPTH];

   typedef struct {
      int          kind;       // 0 read, 1 write, 2 both high
      logic [15:0] addr;
      logic [15:0] wd;
      int          hold;       // edges the request stays high, starting at acceptance
      bit          exp_pulse;
      logic [15:0] exp_data;
      bit          chk_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request and checks every cycle until the bus has settled back to idle.
   task automatic run_txn(input vec_t v, input string tag);
      bit pulse;
      readM     = (v.kind == 0) || (v.kind == 2);
      writeM    = (v.kind == 1) || (v.kind == 2);
      address   = v.addr;
      cpu_wdata = v.wd;
      cpu_oe    = writeM;
      for (int i = 0; i <= v.hold + 1; i++) begin
         step();
         if (i == v.hold - 1) begin
            readM   = 1'b0;
            writeM  = 1'b0;
            cpu_oe  = 1'b0;
            address = 16'($urandom);
         end
         pulse = v.exp_pulse && (i == LAT);
         check($sformatf("%s/c%0d/ready", tag, i), 32'(inputReady), 32'(pulse && v.kind == 0));
         check($sformatf("%s/c%0d/ack", tag, i), 32'(ackOutput), 32'(pulse && v.kind == 1));
         check($sformatf("%s/c%0d/drive", tag, i), 32'(dut.drive), 32'(pulse && v.kind == 0));
         if (pulse && v.kind == 0 && v.chk_data)
            check($sformatf("%s/c%0d/data", tag, i), 32'(data), 32'(v.exp_data));
      end
      if (v.kind == 1 && v.exp_pulse) begin
         ref_mem[v.addr % DEPTH]   = v.wd;
         ref_valid[v.addr % DEPTH] = 1'b1;
      end
   endtask

   initial begin
      vec_t v;
      int   idx;

      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = '0;
         ref_valid[i] = 1'b0;
      end

      reset = 1'b1; readM = 1'b0; writeM = 1'b0;
      address = '0; cpu_wdata = '0; cpu_oe = 1'b0;
      repeat (3) step();
      check("reset/ready", 32'(inputReady), 32'd0);
      check("reset/ack", 32'(ackOutput), 32'd0);
      check("reset/drive", 32'(dut.drive), 32'd0);
      reset = 1'b0;
      step();

      vecs.push_back('{1, 16'h0005, 16'h1234, 3, 1'b1, 16'h0000, 1'b0});
      vecs.push_back('{0, 16'h0005, 16'h0000, 3, 1'b1, 16'h1234, 1'b1});
      vecs.push_back('{0, 16'h0005, 16'h0000, 8, 1'b1, 16'h1234, 1'b1});
      vecs.push_back('{1, 16'h0103, 16'hBEEF, 3, 1'b1, 16'h0000, 1'b0});
      vecs.push_back('{0, 16'h0003, 16'h0000, 3, 1'b1, 16'hBEEF, 1'b1});
      vecs.push_back('{2, 16'h0005, 16'hDEAD, 3, 1'b0, 16'h0000, 1'b0});
      vecs.push_back('{0, 16'h0005, 16'h0000, 3, 1'b1, 16'h1234, 1'b1});
      vecs.push_back('{1, 16'h0007, 16'h5555, 4, 1'b1, 16'h0000, 1'b0});
      vecs.push_back('{1, 16'h0007, 16'hAAAA, 2, 1'b0, 16'h0000, 1'b0});
      vecs.push_back('{0, 16'h0007, 16'h0000, 3, 1'b1, 16'h5555, 1'b1});
      vecs.push_back('{1, 16'hFF07, 16'h0F0F, 1, 1'b0, 16'h0000, 1'b0});
      vecs.push_back('{0, 16'h0107, 16'h0000, 3, 1'b1, 16'h5555, 1'b1});

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Reset sampled on the edge that would have committed a write.
      writeM = 1'b1; readM = 1'b0; address = 16'h0007;
      cpu_wdata = 16'hAAAA; cpu_oe = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      check("rstwait/ack", 32'(ackOutput), 32'd0);
      check("rstwait/ready", 32'(inputReady), 32'd0);
      check("rstwait/drive", 32'(dut.drive), 32'd0);
      reset = 1'b0; writeM = 1'b0; cpu_oe = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rstwait/post%0d/ack", i), 32'(ackOutput), 32'd0);
      end
      run_txn('{0, 16'h0007, 16'h0000, 3, 1'b1, 16'h5555, 1'b1}, "rstwait/read");

      for (int n = 0; n < 80; n++) begin
         v.kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
         v.addr = (16'($urandom_range(0, 255)) << 8) | 16'($urandom_range(0, 7));
         v.wd   = 16'($urandom);
         v.hold = int'($urandom_range(1, 6));
         idx    = int'(v.addr % DEPTH);
         v.exp_pulse = (v.kind != 2) && (v.hold >= LAT + 1);
         v.exp_data  = ref_mem[idx];
         v.chk_data  = ref_valid[idx];
         run_txn(v, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
